sensor_reg_seq: RTL and testbench
=================================

# sensor_reg_seq

Parametrised camera-sensor register-initialisation sequencer. Walks an external combinational register table indexed by `lut_index` and issues one I2C register write per entry to the I2C master through a request/done handshake. Supports in-table millisecond delays, an end marker, and NACK retry with error reporting. Sits between the sensor-specific table module (OV5640 and successors) and the shared I2C master, and gates the capture path via `done`.

## Interface
- `REG_ADDR_W`, 16: register address width; 8 or 16 only.
- `DATA_W`, 8: register data width; 8 or 16.
- `INDEX_W`, 10: table index width.
- `CLK_FREQ`, 50_000_000: clk frequency in Hz; sets the ms tick period `CLK_FREQ/1000`.
- `MAX_RETRY`, 3: reissues allowed per entry after a NACK.
- `ENTRY_W`, `8+REG_ADDR_W+DATA_W`: derived; must not be overridden.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins the sequence from index 0; ignored while `busy`.
- `lut_index`  out  INDEX_W  table address, registered.
- `lut_data`  in  ENTRY_W  `{dev_addr[7:0], reg_addr, data}` for `lut_index`, combinational.
- `i2c_req`  out  1  write request; level, held until `i2c_done`.
- `i2c_dev_addr`  out  8  8-bit device write address.
- `i2c_reg_addr`  out  REG_ADDR_W  register address.
- `i2c_addr_16`  out  1  constant `REG_ADDR_W==16`.
- `i2c_wdata`  out  DATA_W  register data.
- `i2c_done`  in  1  one-cycle pulse when the master finishes a transaction.
- `i2c_nack`  in  1  valid only with `i2c_done`; 1 means the slave NACKed.
- `busy`, `done`, `error`  out  1  status levels.
- `err_index`  out  INDEX_W  index of the failing entry.

## Operation
- Entry decode by `dev_addr`:
  - 8'hFF means END.
  - 8'hFE means DELAY; the low 16 bits of `{reg_addr,data}` give the delay in ms.
  - Any other value means WRITE.
  - 8'h00 (the table default) is also treated as END, so a missing marker cannot overrun the table.
- FSM states:
  - IDLE: `start` clears `lut_index`, `done`, `error` and the retry count, then goes to FETCH.
  - FETCH: registers `lut_data` into the entry latch, then goes to DECODE.
  - DECODE:
    - WRITE: drive the outputs from the latch, assert `i2c_req`, go to WAIT_I2C.
    - DELAY: load the ms counter and go to DELAY. A delay of 0 goes directly to NEXT.
    - END: go to DONE.
  - WAIT_I2C: on `i2c_done`:
    - `!i2c_nack`: go to NEXT.
    - NACK with retry count < MAX_RETRY: increment the count, go to DECODE, reissue the same entry.
    - Otherwise: latch `err_index=lut_index` and go to ERROR.
  - DELAY: decrement the counter on each ms tick; at zero go to NEXT.
  - NEXT: `lut_index+1`, clear the retry count, go to FETCH. If `lut_index` is all ones, go to DONE instead (no wrap).
  - DONE: `done=1`. ERROR: `error=1`. Both states return to IDLE only on `start`.
- `i2c_dev_addr`/`i2c_reg_addr`/`i2c_wdata` come from the registered latch and are stable for the whole time `i2c_req` is high.

## Timing
- Reset values:
  - `lut_index=0`; `i2c_req`, `busy`, `done`, `error` = 0; `err_index=0`.
  - `i2c_*` data outputs 0; FSM in IDLE; ms prescaler and counter 0.
- `busy=1` in every state except IDLE, DONE and ERROR.
- `start` to the first `i2c_req` rising edge: 3 cycles (IDLE→FETCH→DECODE→WAIT_I2C).
- `i2c_done` to the next `i2c_req`: 4 cycles (NEXT, FETCH, DECODE, WAIT_I2C).
- Retry: `i2c_req` drops for 1 cycle (DECODE), then reasserts.
- `i2c_req` deasserts in the cycle after `i2c_done` is sampled.
- `i2c_done` outside WAIT_I2C is ignored.
- DELAY of N ms:
  - The prescaler restarts on DELAY entry.
  - Elapsed time is N×(CLK_FREQ/1000) cycles ±1 cycle.
- `start` arriving in the same cycle as a DONE/ERROR entry is ignored.
- `rst_n` low mid-transaction drops `i2c_req` asynchronously. The master must tolerate an abandoned request.

## Structure
- Package `sensor_seq_pkg`:
  - FSM state enum.
  - `DEV_END=8'hFF`, `DEV_NULL=8'h00`, `DEV_DELAY=8'hFE`.
  - Entry-field slice helpers.
- Sub-module `ms_tick_gen`:
  - Parameter CLK_FREQ; inputs `clk`, `rst_n`, `clr`; output `tick`.
  - `tick` is a one-cycle pulse every CLK_FREQ/1000 cycles.

## Test plan
- CLK_FREQ=1000 (1 cycle/ms) for fast simulation. Model the table as `{78,3103,11},{78,3008,82},{FE,0005 delay},{78,3008,42},{FF,...}` with a master model that returns `i2c_done` 10 cycles after the request.
  - Expect exactly 3 writes, with address/data matching the table.
  - Expect a 5-tick gap after the second write.
  - Expect `done=1` and `lut_index=4`.
- First write NACKed twice, then ACKed → 3 requests with identical fields, each separated by a 1-cycle low on `i2c_req`; then normal progress.
- Every attempt NACKed with MAX_RETRY=3 → 4 requests; `error=1`, `err_index=0`, `busy=0`, no further requests.
- `start` pulsed while `busy` → ignored, no index reset. `start` after DONE → the sequence reruns from index 0.
- `rst_n` asserted while `i2c_req=1` at index 2 → outputs return to reset values immediately. A later `start` restarts from index 0.
- REG_ADDR_W=8, DATA_W=16 table ending in `dev_addr=00` → `i2c_addr_16=0`, 16-bit data is driven correctly, and the sequence terminates on the 00 entry.

Source files
------------

// File: rtl/sensor_seq_pkg.sv
// Shared types, table markers and entry-field helpers for the sensor register sequencer.
package sensor_seq_pkg;

   localparam int unsigned DEV_W   = 8;
   localparam int unsigned DELAY_W = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_WAIT_I2C,
      S_DELAY,
      S_NEXT,
      S_DONE,
      S_ERROR
   } seq_state_e;

   typedef enum logic [1:0] {
      ENT_WRITE,
      ENT_DELAY,
      ENT_END
   } entry_kind_e;

   localparam logic [DEV_W-1:0] DEV_END   = 8'hFF;
   localparam logic [DEV_W-1:0] DEV_NULL  = 8'h00;
   localparam logic [DEV_W-1:0] DEV_DELAY = 8'hFE;

   // An all-zero device address is the table default, so it terminates like END.
   function automatic entry_kind_e entry_kind(input logic [DEV_W-1:0] dev);
      entry_kind_e kind;
      if (dev == DEV_END || dev == DEV_NULL) begin
         kind = ENT_END;
      end else if (dev == DEV_DELAY) begin
         kind = ENT_DELAY;
      end else begin
         kind = ENT_WRITE;
      end
      return kind;
   endfunction

   // Entry layout is {dev_addr, reg_addr, data}; these give the field LSB positions.
   function automatic int unsigned dev_lsb(input int unsigned reg_w, input int unsigned data_w);
      return reg_w + data_w;
   endfunction

   function automatic int unsigned reg_lsb(input int unsigned data_w);
      return data_w;
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond strobe: one-cycle tick every CLK_FREQ/1000 clocks, restartable with clr.
module ms_tick_gen #(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int unsigned PERIOD   = (CLK_FREQ >= 1000) ? (CLK_FREQ / 1000) : 1;
   localparam int unsigned CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (clr) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt  <= '0;
         r_tick <= 1'b1;
      end else begin
         r_cnt  <= r_cnt + CNT_W'(1);
         r_tick <= 1'b0;
      end
   end

   assign tick = r_tick;

endmodule

// File: rtl/sensor_reg_seq.sv
// Camera-sensor register-init sequencer: walks a register table and issues one
// I2C write per entry, with in-table ms delays, end markers and NACK retry.
module sensor_reg_seq
   import sensor_seq_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 16,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned INDEX_W    = 10,
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned MAX_RETRY  = 3,
   parameter int unsigned ENTRY_W    = 8 + REG_ADDR_W + DATA_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [INDEX_W-1:0]    lut_index,
   input  logic [ENTRY_W-1:0]    lut_data,
   output logic                  i2c_req,
   output logic [7:0]            i2c_dev_addr,
   output logic [REG_ADDR_W-1:0] i2c_reg_addr,
   output logic                  i2c_addr_16,
   output logic [DATA_W-1:0]     i2c_wdata,
   input  logic                  i2c_done,
   input  logic                  i2c_nack,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [INDEX_W-1:0]    err_index
);

   localparam int unsigned DEV_LSB = dev_lsb(REG_ADDR_W, DATA_W);
   localparam int unsigned REG_LSB = reg_lsb(DATA_W);
   localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   seq_state_e r_state, w_state_nxt;

   logic [INDEX_W-1:0]    r_lut_index;
   logic [INDEX_W-1:0]    r_err_index;
   logic [ENTRY_W-1:0]    r_entry;
   logic [RETRY_W-1:0]    r_retry;
   logic [DELAY_W-1:0]    r_ms_cnt;
   logic [7:0]            r_dev_addr;
   logic [REG_ADDR_W-1:0] r_reg_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic                  r_req;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_error;

   logic [DEV_W-1:0]      w_dev;
   logic [REG_ADDR_W-1:0] w_reg;
   logic [DATA_W-1:0]     w_data;
   logic [DELAY_W-1:0]    w_delay_ms;
   entry_kind_e           w_kind;
   logic                  w_last_index;
   logic                  w_tick;
   logic                  w_retry_ok;

   logic w_req_nxt, w_busy_nxt, w_done_nxt, w_error_nxt;
   logic w_start_seq, w_load_entry, w_load_fields, w_load_delay;
   logic w_tick_clr, w_retry_inc, w_retry_clr, w_err_latch, w_advance, w_ms_dec;

   assign w_dev        = r_entry[DEV_LSB +: DEV_W];
   assign w_reg        = r_entry[REG_LSB +: REG_ADDR_W];
   assign w_data       = r_entry[DATA_W-1:0];
   assign w_delay_ms   = r_entry[DELAY_W-1:0];
   assign w_kind       = entry_kind(w_dev);
   assign w_last_index = &r_lut_index;
   assign w_retry_ok   = (r_retry < RETRY_MAX);

   ms_tick_gen #(
      .CLK_FREQ (CLK_FREQ)
   ) u_ms_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_tick_clr),
      .tick  (w_tick)
   );

   // State register; status and request outputs are registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_req   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= w_req_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_error <= w_error_nxt;
      end
   end

   // Next-state logic. A start in DONE/ERROR re-enters the sequence directly,
   // equivalent to returning to IDLE and taking the start there.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:     if (start) w_state_nxt = S_FETCH;
         S_FETCH:    w_state_nxt = S_DECODE;
         S_DECODE: begin
            unique case (w_kind)
               ENT_WRITE: w_state_nxt = S_WAIT_I2C;
               ENT_DELAY: w_state_nxt = (w_delay_ms == '0) ? S_NEXT : S_DELAY;
               default:   w_state_nxt = S_DONE;
            endcase
         end
         S_WAIT_I2C: begin
            if (i2c_done) begin
               if (!i2c_nack)       w_state_nxt = S_NEXT;
               else if (w_retry_ok) w_state_nxt = S_DECODE;
               else                 w_state_nxt = S_ERROR;
            end
         end
         S_DELAY:    if (w_tick && r_ms_cnt == DELAY_W'(1)) w_state_nxt = S_NEXT;
         S_NEXT:     w_state_nxt = w_last_index ? S_DONE : S_FETCH;
         S_DONE:     if (start) w_state_nxt = S_FETCH;
         S_ERROR:    if (start) w_state_nxt = S_FETCH;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // Output and datapath-control decode.
   always_comb begin
      w_req_nxt     = 1'b0;
      w_busy_nxt    = 1'b0;
      w_done_nxt    = 1'b0;
      w_error_nxt   = 1'b0;
      w_start_seq   = 1'b0;
      w_load_entry  = 1'b0;
      w_load_fields = 1'b0;
      w_load_delay  = 1'b0;
      w_tick_clr    = 1'b0;
      w_retry_inc   = 1'b0;
      w_retry_clr   = 1'b0;
      w_err_latch   = 1'b0;
      w_advance     = 1'b0;
      w_ms_dec      = 1'b0;

      w_req_nxt   = (w_state_nxt == S_WAIT_I2C);
      w_busy_nxt  = !(w_state_nxt inside {S_IDLE, S_DONE, S_ERROR});
      w_done_nxt  = (w_state_nxt == S_DONE);
      w_error_nxt = (w_state_nxt == S_ERROR);

      w_start_seq   = start && (r_state inside {S_IDLE, S_DONE, S_ERROR});
      w_load_entry  = (r_state == S_FETCH);
      w_load_fields = (r_state == S_DECODE) && (w_kind == ENT_WRITE);
      w_load_delay  = (r_state == S_DECODE) && (w_kind == ENT_DELAY);
      w_tick_clr    = w_load_delay;
      w_ms_dec      = (r_state == S_DELAY) && w_tick && (r_ms_cnt != '0);
      w_retry_inc   = (r_state == S_WAIT_I2C) && i2c_done && i2c_nack && w_retry_ok;
      w_retry_clr   = (r_state == S_NEXT) || w_start_seq;
      w_err_latch   = (r_state == S_WAIT_I2C) && (w_state_nxt == S_ERROR);
      w_advance     = (r_state == S_NEXT) && !w_last_index;
   end

   // Table index, entry latch, retry and ms counters, I2C payload registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lut_index <= '0;
         r_err_index <= '0;
         r_entry     <= '0;
         r_retry     <= '0;
         r_ms_cnt    <= '0;
         r_dev_addr  <= '0;
         r_reg_addr  <= '0;
         r_wdata     <= '0;
      end else begin
         if (w_start_seq) begin
            r_lut_index <= '0;
         end else if (w_advance) begin
            r_lut_index <= r_lut_index + INDEX_W'(1);
         end

         if (w_retry_clr) begin
            r_retry <= '0;
         end else if (w_retry_inc) begin
            r_retry <= r_retry + RETRY_W'(1);
         end

         if (w_load_entry) r_entry <= lut_data;

         if (w_load_fields) begin
            r_dev_addr <= w_dev;
            r_reg_addr <= w_reg;
            r_wdata    <= w_data;
         end

         if (w_load_delay) begin
            r_ms_cnt <= w_delay_ms;
         end else if (w_ms_dec) begin
            r_ms_cnt <= r_ms_cnt - DELAY_W'(1);
         end

         if (w_err_latch) r_err_index <= r_lut_index;
      end
   end

   assign lut_index    = r_lut_index;
   assign err_index    = r_err_index;
   assign i2c_req      = r_req;
   assign i2c_dev_addr = r_dev_addr;
   assign i2c_reg_addr = r_reg_addr;
   assign i2c_wdata    = r_wdata;
   assign i2c_addr_16  = (REG_ADDR_W == 16);
   assign busy         = r_busy;
   assign done         = r_done;
   assign error        = r_error;

endmodule

// File: tb/tb_sensor_reg_seq.sv
// Scoreboard bench for sensor_reg_seq: reference walk of the table queues the
// expected I2C requests; monitors pop and compare as the DUTs issue them.
module tb_sensor_reg_seq;

   localparam int IDX_W = 10;
   localparam int TBL_N = 1 << IDX_W;
   localparam int MS_CYC = 1;
   localparam int MAX_R = 3;

   typedef struct {
      logic [7:0]  dev;
      logic [15:0] rg;
      logic [7:0]  dat;
      int          gap_lo;
      int          gap_hi;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // DUT A: 16-bit register address, 8-bit data
   logic             start_a;
   logic [IDX_W-1:0] lut_index_a;
   logic [31:0]      lut_data_a;
   logic             req_a;
   logic [7:0]       dev_a;
   logic [15:0]      reg_a;
   logic             addr16_a;
   logic [7:0]       wdata_a;
   logic             idone_a;
   logic             inack_a;
   logic             busy_a, done_a, error_a;
   logic [IDX_W-1:0] err_index_a;

   // DUT B: 8-bit register address, 16-bit data
   logic             start_b;
   logic [IDX_W-1:0] lut_index_b;
   logic [31:0]      lut_data_b;
   logic             req_b;
   logic [7:0]       dev_b;
   logic [7:0]       reg_b;
   logic             addr16_b;
   logic [15:0]      wdata_b;
   logic             idone_b;
   logic             inack_b;
   logic             busy_b, done_b, error_b;
   logic [IDX_W-1:0] err_index_b;

   logic [31:0] tbl_a [0:TBL_N-1];
   int          nack_plan [0:TBL_N-1];
   int          attempts  [0:TBL_N-1];
   logic [31:0] tbl_b [0:3];

   exp_t        sb_a[$];
   logic [31:0] sb_b[$];

   int n_cmp = 0;
   int n_fail = 0;
   int lat_lo = 10;
   int lat_hi = 10;
   bit exp_done, exp_err, first_is_write;
   int exp_idx, exp_err_idx;

   assign lut_data_a = tbl_a[lut_index_a];
   assign lut_data_b = (lut_index_b < IDX_W'(4)) ? tbl_b[lut_index_b[1:0]] : 32'h0;

   sensor_reg_seq #(
      .REG_ADDR_W (16), .DATA_W (8), .INDEX_W (IDX_W), .CLK_FREQ (1000), .MAX_RETRY (MAX_R)
   ) u_dut_a (
      .clk (clk), .rst_n (rst_n), .start (start_a), .lut_index (lut_index_a),
      .lut_data (lut_data_a), .i2c_req (req_a), .i2c_dev_addr (dev_a),
      .i2c_reg_addr (reg_a), .i2c_addr_16 (addr16_a), .i2c_wdata (wdata_a),
      .i2c_done (idone_a), .i2c_nack (inack_a), .busy (busy_a), .done (done_a),
      .error (error_a), .err_index (err_index_a)
   );

   sensor_reg_seq #(
      .REG_ADDR_W (8), .DATA_W (16), .INDEX_W (IDX_W), .CLK_FREQ (1000), .MAX_RETRY (MAX_R)
   ) u_dut_b (
      .clk (clk), .rst_n (rst_n), .start (start_b), .lut_index (lut_index_b),
      .lut_data (lut_data_b), .i2c_req (req_b), .i2c_dev_addr (dev_b),
      .i2c_reg_addr (reg_b), .i2c_addr_16 (addr16_b), .i2c_wdata (wdata_b),
      .i2c_done (idone_b), .i2c_nack (inack_b), .busy (busy_b), .done (done_b),
      .error (error_b), .err_index (err_index_b)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d..%0d at %0t", nm, act, lo, hi, $time);
      end
   endtask

   // I2C master model A: done after a random latency, NACKs the first nack_plan[idx] attempts.
   initial begin : master_a
      int  cd;
      bit  pend;
      int  idx;
      pend = 1'b0;
      cd = 0;
      idone_a = 1'b0;
      inack_a = 1'b0;
      forever begin
         @(negedge clk);
         idone_a = 1'b0;
         inack_a = 1'b0;
         if (!rst_n) begin
            pend = 1'b0;
         end else if (pend) begin
            if (cd <= 1) begin
               idx = int'(lut_index_a);
               idone_a = 1'b1;
               inack_a = (attempts[idx] < nack_plan[idx]);
               attempts[idx]++;
               pend = 1'b0;
            end else begin
               cd--;
            end
         end else if (req_a) begin
            pend = 1'b1;
            cd = int'($urandom_range(lat_hi, lat_lo));
         end
      end
   end

   // Monitor A: checks fields, idle gap before each request and payload stability.
   initial begin : monitor_a
      bit          prev;
      int          low;
      exp_t        e;
      logic [31:0] cap;
      prev = 1'b0;
      low = 0;
      cap = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev = 1'b0;
            low = 0;
         end else if (req_a && !prev) begin
            if (sb_a.size() == 0) begin
               chk("unexpected_req_a", 64'(lut_index_a), 64'hFFFF_FFFF);
            end else begin
               e = sb_a.pop_front();
               chk("req_fields_a", 64'({dev_a, reg_a, wdata_a}), 64'({e.dev, e.rg, e.dat}));
               if (e.gap_lo >= 0) chk_rng("req_gap_a", low, e.gap_lo, e.gap_hi);
            end
            cap = {dev_a, reg_a, wdata_a};
            low = 0;
         end else if (!req_a && prev) begin
            chk("req_hold_a", 64'({dev_a, reg_a, wdata_a}), 64'(cap));
            low = 1;
         end else if (!req_a) begin
            low++;
         end
         prev = req_a;
      end
   end

   // Master and monitor for DUT B: always ACK after two cycles.
   initial begin : master_b
      int cd;
      bit pend;
      pend = 1'b0;
      cd = 0;
      idone_b = 1'b0;
      inack_b = 1'b0;
      forever begin
         @(negedge clk);
         idone_b = 1'b0;
         if (!rst_n) begin
            pend = 1'b0;
         end else if (pend) begin
            if (cd <= 1) begin
               idone_b = 1'b1;
               pend = 1'b0;
            end else begin
               cd--;
            end
         end else if (req_b) begin
            pend = 1'b1;
            cd = 2;
         end
      end
   end

   initial begin : monitor_b
      bit          prev;
      logic [31:0] e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && req_b && !prev) begin
            if (sb_b.size() == 0) begin
               chk("unexpected_req_b", 64'(lut_index_b), 64'hFFFF_FFFF);
            end else begin
               e = sb_b.pop_front();
               chk("req_fields_b", 64'({dev_b, reg_b, wdata_b}), 64'(e));
            end
         end
         prev = req_b;
      end
   end

   // Reference model: walk the table by its rules and queue every request attempt.
   task automatic build_expect();
      int          idx, lo, hi, n, tries;
      bit          first;
      exp_t        e;
      logic [31:0] ent;
      logic [7:0]  dv;
      idx = 0; lo = -1; hi = -1; first = 1'b1;
      exp_done = 1'b0; exp_err = 1'b0; exp_err_idx = 0; first_is_write = 1'b0;
      for (int i = 0; i < TBL_N; i++) attempts[i] = 0;
      forever begin
         ent = tbl_a[idx];
         dv = ent[31:24];
         if (dv == 8'hFF || dv == 8'h00) begin
            exp_done = 1'b1;
            exp_idx = idx;
            break;
         end
         if (dv == 8'hFE) begin
            n = int'(ent[15:0]);
            // fetch+decode+next per entry, plus the ms wait (+/-1 cycle)
            lo += (n == 0) ? 3 : n * MS_CYC + 3;
            hi += (n == 0) ? 3 : n * MS_CYC + 5;
            idx++;
            continue;
         end
         if (idx == 0) first_is_write = 1'b1;
         tries = (nack_plan[idx] > MAX_R) ? MAX_R + 1 : nack_plan[idx] + 1;
         for (int t = 0; t < tries; t++) begin
            e.dev = dv;
            e.rg = ent[23:8];
            e.dat = ent[7:0];
            e.gap_lo = first ? -1 : lo;
            e.gap_hi = first ? -1 : hi;
            sb_a.push_back(e);
            first = 1'b0;
            lo = 1;
            hi = 1;
         end
         if (nack_plan[idx] > MAX_R) begin
            exp_err = 1'b1;
            exp_err_idx = idx;
            exp_idx = idx;
            break;
         end
         lo = 3;
         hi = 3;
         idx++;
      end
   endtask

   task automatic clear_tables();
      for (int i = 0; i < TBL_N; i++) begin
         tbl_a[i] = 32'h0;
         nack_plan[i] = 0;
      end
   endtask

   task automatic basic_table();
      clear_tables();
      tbl_a[0] = {8'h78, 16'h3103, 8'h11};
      tbl_a[1] = {8'h78, 16'h3008, 8'h82};
      tbl_a[2] = {8'hFE, 24'h00_0005};
      tbl_a[3] = {8'h78, 16'h3008, 8'h42};
      tbl_a[4] = {8'hFF, 24'h0};
   endtask

   task automatic pulse_start();
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      chk("start_index0", 64'(lut_index_a), 64'd0);
      if (first_is_write) begin
         @(negedge clk); chk("req_before_latency", 64'(req_a), 64'd0);
         @(negedge clk); chk("start_to_req_latency", 64'(req_a), 64'd1);
      end
   endtask

   task automatic wait_idle(input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy_a) break;
      end
      if (i == budget) chk("idle_timeout", 64'(busy_a), 64'd0);
   endtask

   task automatic wait_req_at(input int idx, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clk);
         if (req_a && int'(lut_index_a) == idx) break;
      end
      if (i == budget) chk("req_at_timeout", 64'(lut_index_a), 64'(idx));
   endtask

   task automatic check_status();
      repeat (20) @(negedge clk);
      chk("status_done", 64'(done_a), 64'(exp_done));
      chk("status_error", 64'(error_a), 64'(exp_err));
      chk("status_busy", 64'(busy_a), 64'd0);
      chk("status_index", 64'(lut_index_a), 64'(exp_idx));
      if (exp_err) chk("status_err_index", 64'(err_index_a), 64'(exp_err_idx));
      chk("sb_drain_a", 64'(sb_a.size()), 64'd0);
   endtask

   task automatic run_seq();
      build_expect();
      pulse_start();
      wait_idle(4000);
      check_status();
   endtask

   task automatic random_table();
      int len;
      clear_tables();
      len = int'($urandom_range(10, 1));
      for (int i = 0; i < len; i++) begin
         if ($urandom_range(9, 0) < 2) begin
            tbl_a[i] = {8'hFE, 8'($urandom), 16'($urandom_range(3, 0))};
         end else begin
            tbl_a[i] = {8'($urandom_range(253, 1)), 16'($urandom), 8'($urandom)};
            nack_plan[i] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(4, 1)) : 0;
         end
      end
      tbl_a[len] = {($urandom_range(1, 0) == 1) ? 8'hFF : 8'h00, 24'($urandom)};
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      rst_n = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      clear_tables();
      tbl_b[0] = {8'h3C, 8'h12, 16'hABCD};
      tbl_b[1] = {8'h3C, 8'h34, 16'h0102};
      tbl_b[2] = {8'h3C, 8'hFF, 16'hFFFF};
      tbl_b[3] = {8'h00, 8'h55, 16'h5555};
      repeat (3) @(negedge clk);

      // reset values
      chk("rst_index", 64'(lut_index_a), 64'd0);
      chk("rst_req", 64'(req_a), 64'd0);
      chk("rst_status", 64'({busy_a, done_a, error_a}), 64'd0);
      chk("rst_err_index", 64'(err_index_a), 64'd0);
      chk("rst_fields", 64'({dev_a, reg_a, wdata_a}), 64'd0);
      chk("addr16_a", 64'(addr16_a), 64'd1);
      #1 rst_n = 1'b1;

      // basic table: 3 writes, 5 ms delay, END at index 4
      basic_table();
      run_seq();

      // rerun from DONE, with a start pulse while busy that must be ignored
      build_expect();
      pulse_start();
      wait_req_at(1, 200);
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      chk("busy_start_index", 64'(lut_index_a), 64'd1);
      chk("busy_start_busy", 64'(busy_a), 64'd1);
      wait_idle(4000);
      check_status();

      // first write NACKed twice, then ACKed
      basic_table();
      nack_plan[0] = 2;
      run_seq();

      // every attempt NACKed: error at index 0
      basic_table();
      nack_plan[0] = 4;
      run_seq();

      // reset while a request is outstanding at index 2, then restart
      clear_tables();
      tbl_a[0] = {8'h78, 16'h0100, 8'h01};
      tbl_a[1] = {8'h78, 16'h0200, 8'h02};
      tbl_a[2] = {8'h78, 16'h0300, 8'h03};
      tbl_a[3] = {8'h78, 16'h0400, 8'h04};
      tbl_a[4] = {8'hFF, 24'h0};
      build_expect();
      pulse_start();
      wait_req_at(2, 500);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_req", 64'(req_a), 64'd0);
      chk("arst_index", 64'(lut_index_a), 64'd0);
      chk("arst_status", 64'({busy_a, done_a, error_a}), 64'd0);
      chk("arst_fields", 64'({dev_a, reg_a, wdata_a}), 64'd0);
      sb_a.delete();
      @(negedge clk);
      #1 rst_n = 1'b1;
      run_seq();

      // randomized tables, NACK plans and master latency
      lat_lo = 1;
      lat_hi = 12;
      for (int r = 0; r < 14; r++) begin
         random_table();
         run_seq();
      end

      // DUT B: 8-bit register address, 16-bit data, table ends on a 00 entry
      for (int i = 0; i < 3; i++) sb_b.push_back(tbl_b[i]);
      @(negedge clk); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!busy_b) break;
      end
      repeat (10) @(negedge clk);
      chk("addr16_b", 64'(addr16_b), 64'd0);
      chk("b_done", 64'({done_b, error_b, busy_b}), 64'b100);
      chk("b_index", 64'(lut_index_b), 64'd3);
      chk("sb_drain_b", 64'(sb_b.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
